// File: rtl/fpu_pkg.sv
// fpu_pkg: shared IEEE-754 single-precision field widths, float layout and constants
package fpu_pkg;
    localparam int EXP_BIAS = 127;
    localparam int FRAC_W   = 23;
    localparam int EXP_W    = 8;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } float_t;

    localparam float_t FLOAT_POS_ZERO = '{sign: 1'b0, exp: '0, frac: '0};
endpackage

// File: rtl/lzc32.sv
// lzc32: combinational 32-bit leading-zero counter
//   x    in  32  value to scan
//   cnt  out 5   number of leading zeros (0 when x is all-zero)
//   zero out 1   x is all-zero
module lzc32 (
    input  logic [31:0] x,
    output logic [4:0]  cnt,
    output logic        zero
);
    // Scanning upward lets the highest set bit win.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 32; i++)
            if (x[i]) cnt = 5'(31 - i);
    end

    assign zero = ~|x;
endmodule

// File: rtl/itof.sv
// itof: pipelined signed 32-bit integer to IEEE-754 single conversion, round-to-nearest-even
//   clk     in  1   clock
//   rstn    in  1   asynchronous active-low reset
//   en      in  1   pipeline advance enable; 0 holds every stage
//   val_in  in  1   x1 carries a valid operand
//   x1      in  32  two's-complement operand
//   val_out out 1   y is valid
//   y       out 32  {sign, exp, frac}
module itof
    import fpu_pkg::*;
#(
    parameter int NSTAGE = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        val_in,
    input  logic [31:0] x1,
    output logic        val_out,
    output logic [31:0] y
);
    if (NSTAGE != 1 && NSTAGE != 2) begin : g_bad_nstage
        $error("itof: NSTAGE must be 1 or 2");
    end

    logic        sign0, zero0;
    logic [31:0] mag0;
    logic [4:0]  lz0;

    // 2^31 negated stays 2^31 as an unsigned magnitude.
    assign sign0 = x1[31];
    assign mag0  = sign0 ? -x1 : x1;

    lzc32 u_lzc (.x(mag0), .cnt(lz0), .zero(zero0));

    logic        sign_r, zero_r, val_r;
    logic [31:0] mag_r;
    logic [4:0]  lz_r;

    if (NSTAGE == 2) begin : g_two
        always_ff @(posedge clk or negedge rstn)
            if (!rstn) begin
                sign_r <= 1'b0;
                zero_r <= 1'b0;
                val_r  <= 1'b0;
                mag_r  <= '0;
                lz_r   <= '0;
            end else if (en) begin
                sign_r <= sign0;
                zero_r <= zero0;
                val_r  <= val_in;
                mag_r  <= mag0;
                lz_r   <= lz0;
            end
    end else begin : g_one
        assign sign_r = sign0;
        assign zero_r = zero0;
        assign val_r  = val_in;
        assign mag_r  = mag0;
        assign lz_r   = lz0;
    end

    // After normalising, bit 31 is the hidden one, the next FRAC_W bits are kept,
    // then guard and sticky. Values with p <= 23 have all-zero low bits, so they never round.
    function automatic float_t pack(input logic s, input logic [31:0] m, input logic [4:0] lz,
                                    input logic z);
        logic [31:0]     n;
        logic            rnd;
        logic [FRAC_W:0] sum;
        float_t          f;
        n       = m << lz;
        rnd     = n[30-FRAC_W] & ((|n[29-FRAC_W:0]) | n[31-FRAC_W]);
        // A carry out of the kept fraction leaves sum[FRAC_W-1:0] at zero and bumps exp.
        sum     = {1'b0, n[30 -: FRAC_W]} + (FRAC_W+1)'(rnd);
        f.sign  = s;
        f.exp   = EXP_W'(EXP_BIAS + 31) - EXP_W'(lz) + EXP_W'(sum[FRAC_W]);
        f.frac  = sum[FRAC_W-1:0];
        return z ? FLOAT_POS_ZERO : f;
    endfunction

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            y       <= '0;
            val_out <= 1'b0;
        end else if (en) begin
            y       <= pack(sign_r, mag_r, lz_r, zero_r);
            val_out <= val_r;
        end
endmodule

// File: tb/tb_itof.sv
// tb_itof: directed table, handshake/reset sequences and random stream for itof (NSTAGE=2)
module tb_itof;
    logic        clk = 1'b0;
    logic        rstn, en, val_in, val_out;
    logic [31:0] x1, y;
    int          pass = 0;
    int          total = 0;

    itof #(.NSTAGE(2)) dut (
        .clk(clk), .rstn(rstn), .en(en), .val_in(val_in),
        .x1(x1), .val_out(val_out), .y(y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] f;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) pass++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    // Independent reference: the int is exact in double precision, then the double is
    // rounded to single with nearest-even on the 29 dropped mantissa bits.
    function automatic logic [31:0] model(input logic [31:0] x);
        logic [63:0] d;
        logic [28:0] rem;
        logic [23:0] m;
        logic [7:0]  e;
        logic        up;
        if (x == 32'h0) return 32'h0;
        d   = $realtobits(real'($signed(x)));
        e   = 8'(d[62:52] - 11'd896);
        rem = d[28:0];
        up  = (rem > 29'h10000000) || (rem == 29'h10000000 && d[29]);
        m   = {1'b0, d[51:29]} + 24'(up);
        return {d[63], e + 8'(m[23]), m[22:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] prev;
        tbl = '{
            '{32'h00000001, 32'h3F800000}, '{32'hFFFFFFFF, 32'hBF800000},
            '{32'h00000000, 32'h00000000}, '{32'h00000064, 32'h42C80000},
            '{32'h80000000, 32'hCF000000}, '{32'h7FFFFFFF, 32'h4F000000},
            '{32'h01000001, 32'h4B800000}, '{32'h01000003, 32'h4B800002},
            '{32'h01000005, 32'h4B800002}, '{32'h01000007, 32'h4B800004},
            '{32'h01000002, 32'h4B800001}, '{32'h00FFFFFF, 32'h4B7FFFFF},
            '{32'hFFFFFF9C, 32'hC2C80000}, '{32'h00000003, 32'h40400000},
            '{32'h7FFFFFC0, 32'h4F000000}, '{32'h7FFFFF80, 32'h4EFFFFFF}
        };
        rstn = 1'b0; en = 1'b1; val_in = 1'b0; x1 = 32'h0;
        #12;
        chk("reset_y", y, 32'h0);
        chk("reset_val", 32'(val_out), 32'h0);
        @(negedge clk) rstn = 1'b1;

        // Directed table, one operand per cycle, result one edge after capture.
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin x1 = tbl[i].x; val_in = 1'b1; end
            else val_in = 1'b0;
            tick();
            if (i > 0) begin
                chk($sformatf("vec%0d_val", i-1), 32'(val_out), 32'h1);
                chk($sformatf("vec%0d_y", i-1), y, tbl[i-1].f);
            end
        end
        tick();
        chk("bubble_val", 32'(val_out), 32'h0);

        // Stall: A=1 reaches the output, B=-1 sits in stage 1, C=100 waits at the input.
        x1 = 32'h1; val_in = 1'b1; tick();
        x1 = 32'hFFFFFFFF; tick();
        chk("stall_a_y", y, 32'h3F800000);
        en = 1'b0; x1 = 32'h00000064;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold%0d_y", i), y, 32'h3F800000);
            chk($sformatf("hold%0d_val", i), 32'(val_out), 32'h1);
        end
        en = 1'b1; tick();
        chk("after_b_y", y, 32'hBF800000);
        chk("after_b_val", 32'(val_out), 32'h1);
        val_in = 1'b0; tick();
        chk("after_c_y", y, 32'h42C80000);
        chk("after_c_val", 32'(val_out), 32'h1);
        tick();
        chk("slot_bubble_val", 32'(val_out), 32'h0);

        // Reset with two valid operands in flight (7 in stage 1, 9 at the input).
        x1 = 32'h5; val_in = 1'b1; tick();
        x1 = 32'h7; tick();
        chk("pre_rst_y", y, 32'h40A00000);
        x1 = 32'h9;
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_y", y, 32'h0);
        chk("async_rst_val", 32'(val_out), 32'h0);
        val_in = 1'b0;
        @(negedge clk) rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst%0d_val", i), 32'(val_out), 32'h0);
        end

        // Random stream against the double-precision reference.
        prev = 32'h0;
        for (int i = 0; i <= 20000; i++) begin
            if (i < 20000) begin x1 = $urandom; val_in = 1'b1; end
            else val_in = 1'b0;
            tick();
            if (i > 0) begin
                chk("rand_val", 32'(val_out), 32'h1);
                chk("rand_y", y, prev);
            end
            prev = model(x1);
        end

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
